// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - hazard, forwarding and halt/step run-control for the MIPS pipeline
module pipeline_control_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int NUM_FWD      = 2,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32,
   parameter int SEL_W        = $clog2(NUM_FWD + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [REG_ADDR_W-1:0]         i_rs_ID,
   input  logic [REG_ADDR_W-1:0]         i_rt_ID,
   input  logic [REG_ADDR_W-1:0]         i_rs_EX,
   input  logic [REG_ADDR_W-1:0]         i_rt_EX,
   input  logic                          i_mem_read_EX,
   input  logic [REG_ADDR_W-1:0]         i_write_reg_EX,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_dest,
   input  logic [NUM_FWD-1:0]            i_fwd_write,
   input  logic                          i_jump_ID,
   input  logic                          i_halt_instr_ID,
   input  logic                          i_ext_halt,
   input  logic                          i_debug_mode,
   input  logic                          i_step,
   output logic [SEL_W-1:0]              o_corto_rs,
   output logic [SEL_W-1:0]              o_corto_rt,
   output logic                          o_stall,
   output logic                          o_flush_IF,
   output logic                          o_pipe_enable,
   output logic                          o_halted,
   output logic [1:0]                    o_state,
   output logic [CNT_W-1:0]              o_cycle_count
);

   localparam int DC_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            state;
   logic [DC_W-1:0]   drain_cnt;
   logic              halted_q;
   logic [CNT_W-1:0]  cycle_cnt;
   logic              load_use;
   logic              halt_req;
   logic              pipe_enable;

   // Walk from the farthest source inward so the nearest matching source overwrites.
   function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
      logic [SEL_W-1:0]      sel;
      logic [REG_ADDR_W-1:0] dest;
      sel = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         dest = i_fwd_dest[k*REG_ADDR_W +: REG_ADDR_W];
         if (i_fwd_write[k] && (dest == src) && (dest != '0)) begin
            sel = SEL_W'(k + 1);
         end
      end
      return sel;
   endfunction

   always_comb begin
      o_corto_rs = fwd_sel(i_rs_EX);
      o_corto_rt = fwd_sel(i_rt_EX);
   end

   assign load_use = i_mem_read_EX && (i_write_reg_EX != '0) &&
                     ((i_write_reg_EX == i_rs_ID) || (i_write_reg_EX == i_rt_ID));

   // A HALT sitting behind a load-use bubble is re-presented next cycle, so it waits.
   assign halt_req    = i_ext_halt || (i_halt_instr_ID && !load_use);
   assign pipe_enable = (state != ST_HALTED) && (!i_debug_mode || i_step);

   assign o_pipe_enable = pipe_enable;
   assign o_stall       = (state == ST_DRAIN) || ((state == ST_RUN) && load_use);
   assign o_flush_IF    = (state == ST_RUN) && i_jump_ID && !load_use;
   assign o_halted      = halted_q;
   assign o_state       = state;
   assign o_cycle_count = cycle_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         halted_q  <= 1'b0;
         cycle_cnt <= '0;
      end else if (pipe_enable) begin
         if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
         end
         case (state)
            ST_RUN: begin
               if (halt_req) begin
                  if (DRAIN_CYCLES == 0) begin
                     state    <= ST_HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DC_W'(DRAIN_CYCLES);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt <= DC_W'(1)) begin
                  state     <= ST_HALTED;
                  halted_q  <= 1'b1;
                  drain_cnt <= '0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state     <= ST_RUN;
               drain_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - scoreboard bench for pipeline_control_unit
module tb_pipeline_control_unit;

   logic        clk = 1'b0;
   logic        reset, s_reset;
   logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, wr_ex;
   logic        mem_read, jump, halt_instr, ext_halt, debug_mode, step;
   logic [9:0]  fwd_dest;
   logic [1:0]  fwd_write;
   logic [1:0]  corto_rs, corto_rt;
   logic        stall, flush_if, pipe_enable, halted;
   logic [1:0]  state;
   logic [31:0] cycle_count;

   logic [4:0]  z5 = '0;
   logic [9:0]  z10 = '0;
   logic [1:0]  z2 = '0;
   logic        z1 = 1'b0;
   logic [1:0]  s_corto_rs, s_corto_rt, s_state;
   logic        s_stall, s_flush, s_en, s_halted;
   logic [3:0]  s_count;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_cnt = 0;
   int          s_cnt = 0;
   bit          m_halted = 0;

   typedef struct {
      int          stamp;
      int          sel;
      logic [31:0] exp_v;
   } exp_t;
   exp_t  q[$];
   string nq[$];

   pipeline_control_unit dut (
      .i_clk(clk), .i_reset(reset), .i_rs_ID(rs_id), .i_rt_ID(rt_id),
      .i_rs_EX(rs_ex), .i_rt_EX(rt_ex), .i_mem_read_EX(mem_read),
      .i_write_reg_EX(wr_ex), .i_fwd_dest(fwd_dest), .i_fwd_write(fwd_write),
      .i_jump_ID(jump), .i_halt_instr_ID(halt_instr), .i_ext_halt(ext_halt),
      .i_debug_mode(debug_mode), .i_step(step), .o_corto_rs(corto_rs),
      .o_corto_rt(corto_rt), .o_stall(stall), .o_flush_IF(flush_if),
      .o_pipe_enable(pipe_enable), .o_halted(halted), .o_state(state),
      .o_cycle_count(cycle_count)
   );

   pipeline_control_unit #(.CNT_W(4)) dut_sat (
      .i_clk(clk), .i_reset(s_reset), .i_rs_ID(z5), .i_rt_ID(z5),
      .i_rs_EX(z5), .i_rt_EX(z5), .i_mem_read_EX(z1),
      .i_write_reg_EX(z5), .i_fwd_dest(z10), .i_fwd_write(z2),
      .i_jump_ID(z1), .i_halt_instr_ID(z1), .i_ext_halt(z1),
      .i_debug_mode(z1), .i_step(z1), .o_corto_rs(s_corto_rs),
      .o_corto_rt(s_corto_rt), .o_stall(s_stall), .o_flush_IF(s_flush),
      .o_pipe_enable(s_en), .o_halted(s_halted), .o_state(s_state),
      .o_cycle_count(s_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int S_RS = 0, S_RT = 1, S_STALL = 2, S_FLUSH = 3, S_EN = 4,
                  S_HALTED = 5, S_STATE = 6, S_CNT = 7, S_SCNT = 8;

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         S_RS:     return 32'(corto_rs);
         S_RT:     return 32'(corto_rt);
         S_STALL:  return 32'(stall);
         S_FLUSH:  return 32'(flush_if);
         S_EN:     return 32'(pipe_enable);
         S_HALTED: return 32'(halted);
         S_STATE:  return 32'(state);
         S_CNT:    return cycle_count;
         default:  return 32'(s_count);
      endcase
   endfunction

   task automatic expect_now(input int sel, input logic [31:0] v, input string name);
      exp_t e;
      e.stamp = cyc;
      e.sel   = sel;
      e.exp_v = v;
      q.push_back(e);
      nq.push_back(name);
   endtask

   // Advance one clock; the reference counters follow the enable the DUT should see.
   task automatic tick();
      if (reset) begin
         m_cnt = 0;
         m_halted = 0;
      end else if (!m_halted && (!debug_mode || step)) begin
         m_cnt++;
      end
      if (s_reset) s_cnt = 0;
      else if (s_cnt != 15) s_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin : monitor
      exp_t        e;
      string       nm;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].stamp <= cyc) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            a  = actual(e.sel);
            n_cmp++;
            if (e.stamp != cyc) begin
               n_err++;
               $display("FAIL %s: sampled late at cycle %0d, expected cycle %0d", nm, cyc, e.stamp);
            end else if (a !== e.exp_v) begin
               n_err++;
               $display("FAIL %s: got %0d want %0d", nm, a, e.exp_v);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset = 1; s_reset = 1;
      {rs_id, rt_id, rs_ex, rt_ex, wr_ex} = '0;
      {mem_read, jump, halt_instr, ext_halt, debug_mode, step} = '0;
      fwd_dest = '0; fwd_write = '0;

      tick();
      expect_now(S_STATE, 0, "reset_state");
      expect_now(S_HALTED, 0, "reset_halted");
      expect_now(S_CNT, 0, "reset_count");
      expect_now(S_EN, 1, "reset_enable");
      expect_now(S_STALL, 0, "reset_stall");
      reset = 0;

      rs_ex = 5; rt_ex = 7; fwd_dest = {5'd5, 5'd5}; fwd_write = 2'b11;
      expect_now(S_RS, 1, "fwd_nearest_wins");
      expect_now(S_RT, 0, "fwd_rt_nomatch");
      tick();
      fwd_write = 2'b10;
      expect_now(S_RS, 2, "fwd_far_only");
      tick();
      rs_ex = 0; fwd_dest = {5'd0, 5'd0}; fwd_write = 2'b11;
      expect_now(S_RS, 0, "fwd_r0_blocked");
      tick();
      rt_ex = 9; fwd_dest = {5'd9, 5'd3}; fwd_write = 2'b11;
      expect_now(S_RT, 2, "fwd_rt_src1");
      tick();
      fwd_dest = {5'd9, 5'd9}; fwd_write = 2'b01;
      expect_now(S_RT, 1, "fwd_rt_src0");
      tick();
      fwd_write = 2'b00;

      mem_read = 1; wr_ex = 8; rt_id = 8; jump = 1; halt_instr = 1;
      expect_now(S_STALL, 1, "loaduse_stall");
      expect_now(S_FLUSH, 0, "loaduse_no_flush");
      tick();
      halt_instr = 0;
      expect_now(S_STATE, 0, "loaduse_halt_suppressed");
      wr_ex = 0;
      expect_now(S_STALL, 0, "loaduse_r0_nostall");
      expect_now(S_FLUSH, 1, "jump_flush");
      tick();
      mem_read = 0; jump = 0; rt_id = 0;

      debug_mode = 1; ext_halt = 1;
      expect_now(S_EN, 0, "debug_frozen");
      tick();
      expect_now(S_STATE, 0, "halt_ignored_when_frozen");
      expect_now(S_CNT, m_cnt, "count_frozen_debug");
      debug_mode = 0; ext_halt = 0;

      halt_instr = 1;
      tick();
      halt_instr = 0; jump = 1;
      expect_now(S_STATE, 1, "drain_c1_state");
      expect_now(S_STALL, 1, "drain_c1_stall");
      expect_now(S_FLUSH, 0, "drain_no_flush");
      tick();
      jump = 0;
      expect_now(S_STATE, 1, "drain_c2_state");
      tick();
      expect_now(S_STATE, 1, "drain_c3_state");
      expect_now(S_STALL, 1, "drain_c3_stall");
      tick();
      m_halted = 1;
      expect_now(S_STATE, 2, "halted_state");
      expect_now(S_HALTED, 1, "halted_flag");
      expect_now(S_EN, 0, "halted_enable");
      expect_now(S_STALL, 0, "halted_stall");
      expect_now(S_CNT, m_cnt, "halted_count");
      ext_halt = 1; jump = 1;
      ticks(3);
      expect_now(S_STATE, 2, "halted_ext_halt");
      expect_now(S_FLUSH, 0, "halted_flush");
      expect_now(S_CNT, m_cnt, "halted_count_frozen");
      ext_halt = 0; jump = 0;

      reset = 1;
      tick();
      expect_now(S_STATE, 0, "reset_from_halted_state");
      expect_now(S_HALTED, 0, "reset_from_halted_flag");
      expect_now(S_CNT, 0, "reset_from_halted_count");
      reset = 0;

      debug_mode = 1; step = 1; ext_halt = 1;
      tick();
      step = 0; ext_halt = 0;
      expect_now(S_STATE, 1, "step_enter_drain");
      ticks(5);
      expect_now(S_STATE, 1, "step_idle_hold");
      expect_now(S_CNT, m_cnt, "step_idle_count");
      for (int p = 1; p <= 2; p++) begin
         step = 1;
         tick();
         step = 0;
         ticks(4);
         expect_now(S_STATE, 1, $sformatf("step_pulse%0d_state", p));
         expect_now(S_CNT, m_cnt, $sformatf("step_pulse%0d_count", p));
      end
      step = 1;
      tick();
      step = 0;
      m_halted = 1;
      expect_now(S_STATE, 2, "step_pulse3_halted");
      expect_now(S_HALTED, 1, "step_pulse3_flag");
      expect_now(S_CNT, m_cnt, "step_pulse3_count");
      debug_mode = 0;
      expect_now(S_EN, 0, "halted_nodebug_enable");

      reset = 1;
      tick();
      reset = 0; ext_halt = 1;
      tick();
      ext_halt = 0;
      expect_now(S_STATE, 1, "mid_drain_state");
      tick();
      reset = 1;
      tick();
      expect_now(S_STATE, 0, "mid_drain_reset_state");
      expect_now(S_CNT, 0, "mid_drain_reset_count");
      expect_now(S_STALL, 0, "mid_drain_reset_stall");
      reset = 0;
      tick();
      expect_now(S_STATE, 0, "after_reset_run");
      expect_now(S_CNT, m_cnt, "after_reset_count");

      s_reset = 0;
      ticks(14);
      expect_now(S_SCNT, s_cnt, "sat_count14");
      ticks(6);
      expect_now(S_SCNT, 15, "sat_count20");
      ticks(5);
      expect_now(S_SCNT, 15, "sat_hold");

      ticks(2);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Centralised hazard and run-control block for the parametrised MIPS pipeline. It generalises forwarding to NUM_FWD downstream write-back sources with nearest-first priority, and performs load-use stall detection on the true load destination. It adds branch flush, a halt-drain state machine and single-step debug gating. It sits beside IF/ID/EX/MEM/WB and drives their stall, flush and enable inputs.

Parameters:
REG_ADDR_W, 5, register index width
NUM_FWD, 2, forwarding sources; index 0 = nearest (EX/MEM), 1 = MEM/WB, ...
DRAIN_CYCLES, 3, enabled cycles needed to retire in-flight instructions after halt
CNT_W, 32, cycle counter width
SEL_W, $clog2(NUM_FWD+1), forwarding select width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_rs_ID  in  REG_ADDR_W  rs of instruction in ID
i_rt_ID  in  REG_ADDR_W  rt of instruction in ID
i_rs_EX  in  REG_ADDR_W  rs of instruction in EX
i_rt_EX  in  REG_ADDR_W  rt of instruction in EX
i_mem_read_EX  in  1  instruction in EX is a load
i_write_reg_EX  in  REG_ADDR_W  destination of instruction in EX
i_fwd_dest  in  NUM_FWD*REG_ADDR_W  flattened destinations; slice k = source k
i_fwd_write  in  NUM_FWD  register-write flag per source
i_jump_ID  in  1  taken jump/branch resolved in ID
i_halt_instr_ID  in  1  HALT instruction decoded in ID
i_ext_halt  in  1  external halt request (level)
i_debug_mode  in  1  1 = single-step mode
i_step  in  1  one-cycle step pulse
o_corto_rs  out  SEL_W  0 = register file, k+1 = source k
o_corto_rt  out  SEL_W  same encoding
o_stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
o_flush_IF  out  1  clear IF/ID
o_pipe_enable  out  1  global advance enable for all stage registers
o_halted  out  1  pipeline drained and stopped
o_state  out  2  RUN=0, DRAIN=1, HALTED=2
o_cycle_count  out  CNT_W  enabled cycles since reset

Behaviour:
- Reset (sync, i_reset=1 at posedge): state RUN, drain counter 0, o_cycle_count 0, o_halted 0. Combinational outputs follow their rules from the next cycle.
- Forwarding (combinational): o_corto_rs = k+1 for the lowest k such that i_fwd_write[k]=1, dest_k == i_rs_EX and dest_k != 0; else 0. o_corto_rt is the same with i_rt_EX. The nearer source always wins.
- load_use = i_mem_read_EX & (i_write_reg_EX != 0) & (i_write_reg_EX == i_rs_ID | i_write_reg_EX == i_rt_ID).
- o_pipe_enable = (state != HALTED) & (~i_debug_mode | i_step).
- o_stall = (state == DRAIN) | (state == RUN & load_use).
- o_flush_IF = (state == RUN) & i_jump_ID & ~load_use.
- halt_req = i_ext_halt | (i_halt_instr_ID & ~load_use); it is sampled only in RUN with o_pipe_enable=1.
- FSM:
  - RUN: on halt_req, go to DRAIN with counter = DRAIN_CYCLES. If DRAIN_CYCLES == 0, go straight to HALTED.
  - DRAIN: on each o_pipe_enable=1 cycle, decrement the counter. When the counter is 1 and o_pipe_enable=1, go to HALTED next cycle. Disabled cycles hold the counter. i_ext_halt and i_jump_ID are ignored.
  - HALTED: o_halted=1 (registered, asserted on entry), o_pipe_enable=0, o_stall=0, o_flush_IF=0. Only i_reset leaves this state.
- o_cycle_count: +1 on each posedge with o_pipe_enable=1. It saturates at all-ones and does not wrap.
- Debug mode: with i_step low the pipeline is frozen and FSM/counters hold. A step pulse advances exactly one cycle, including a drain step. Toggling i_debug_mode mid-DRAIN is legal.
- Reset mid-DRAIN returns to RUN immediately and clears all counters.

Test Plan:
- Forwarding priority: i_rs_EX=5, i_fwd_dest={5,5}, i_fwd_write=2'b11 -> o_corto_rs=1. Clear i_fwd_write[0] -> o_corto_rs=2. Set dest=0 with write=1 -> o_corto_rs=0.
- Load-use: i_mem_read_EX=1, i_write_reg_EX=8, i_rt_ID=8 -> o_stall=1. Same with i_write_reg_EX=0 -> o_stall=0. Add i_jump_ID=1 during the stall -> o_flush_IF=0.
- Halt drain: DRAIN_CYCLES=3, pulse i_halt_instr_ID in RUN -> o_state=1 for 3 cycles with o_stall=1, then o_state=2, o_halted=1, o_pipe_enable=0. o_cycle_count then freezes.
- Step mode: i_debug_mode=1, halt during DRAIN, give 2 step pulses 5 cycles apart -> o_state stays 1. A 3rd pulse -> HALTED next cycle. o_cycle_count increments by exactly 1 per pulse.
- Reset: assert i_reset in HALTED -> next cycle o_state=0, o_halted=0, o_cycle_count=0. Assert i_ext_halt during HALTED -> no change.
- Saturation: CNT_W=4, 20 enabled cycles -> o_cycle_count=15 and holds.
